instr_fetch_unit: RTL

- Fetch controller that sequences the combinational-read instruction memory.
- Owns the fetch PC and drives the memory address every cycle.
- Buffers fetched words with their PC in a small prefetch queue, presented to decode over a valid/ready handshake.
- Handles branch/jump redirect (queue flush) and a fetch-enable freeze from the hazard unit.

---
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch controller for a combinational-read instruction memory. Owns the fetch
// PC, pushes {instruction, pc} into a small circular prefetch queue and hands
// the head to decode over a valid/ready handshake. A redirect flushes the queue
// and reloads the PC. FetchEnable=0 freezes fetching while the queue drains.
//
// Ports:
//   Clk, Rst         clock, synchronous active-high reset
//   ImemAddress      fetch PC driven to instruction memory
//   ImemInstruction  word returned combinationally for ImemAddress
//   FetchEnable      1 = issue fetches, 0 = hold fetch PC
//   Redirect         taken branch/jump; RedirectPC is the target
//   OutValid/Ready   head-of-queue handshake to decode
//   OutInstruction   head instruction (0 when empty)
//   OutPC            head PC (0 when empty)
//   OutPCPlus4       head PC + 4 (0 when empty)
//   DeliveredCount   accepted handshakes, flushed entries excluded
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  input  logic        FetchEnable,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic [31:0] OutPCPlus4,
  output logic [31:0] DeliveredCount
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q;
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [31:0]      delivered_q;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];

  logic pop, push;

  assign OutValid = (count_q != '0);

  // Redirect wins over both queue operations.
  assign pop  = OutValid & OutReady & ~Redirect;
  assign push = FetchEnable & ~Redirect & ((count_q < CntW'(DEPTH)) | pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_pc_q  <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      delivered_q <= '0;
    end else if (Redirect) begin
      fetch_pc_q <= {RedirectPC[31:2], 2'b00};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + PtrW'(1);
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PtrW'(1);
        delivered_q <= delivered_q + 32'd1;
      end
    end
  end

  // Queue storage carries no reset; count_q alone decides validity.
  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      instr_mem_q[wr_ptr_q] <= ImemInstruction;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign ImemAddress    = fetch_pc_q;
  assign OutInstruction = OutValid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign OutPC          = OutValid ? pc_mem_q[rd_ptr_q] : 32'd0;
  assign OutPCPlus4     = OutValid ? (pc_mem_q[rd_ptr_q] + 32'd4) : 32'd0;
  assign DeliveredCount = delivered_q;

endmodule
